// File: rtl/ifmap_fetch.sv
// rtl/ifmap_fetch.sv - walks a 2-D ifmap tile in byte SRAM and feeds the byte-serial packer word by word
module ifmap_fetch #(
    parameter int BUS    = 31,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [DIM_W-1:0]  pitch,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              ser_en,
    output logic [7:0]        ser_data,
    input  logic              pe_ready,
    output logic              word_valid,
    output logic              word_row_end,
    output logic              word_last,
    output logic              busy,
    output logic              done
);
    localparam int LANES = (BUS + 1) / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_RDY, ISSUE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] row_base;
    logic [DIM_W-1:0]  w_r, h_r, pitch_r;
    logic [DIM_W-1:0]  row, col;
    logic [LW-1:0]     lane;
    logic              rd_q, fin_q, row_end_q, tile_last_q;
    logic              remain, last_slot, col_done, slot_rd;

    // col always holds the column of the next slot to be issued
    assign remain    = (w_r != '0) && (row < h_r);
    assign last_slot = (lane == LW'(LANES - 1));
    assign col_done  = (col >= w_r);
    assign slot_rd   = (col < w_r);
    assign busy      = (state != IDLE);
    assign ser_data  = (ser_en && rd_q) ? mem_rdata : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            row_base     <= '0;
            w_r          <= '0;
            h_r          <= '0;
            pitch_r      <= '0;
            row          <= '0;
            col          <= '0;
            lane         <= '0;
            rd_q         <= 1'b0;
            fin_q        <= 1'b0;
            row_end_q    <= 1'b0;
            tile_last_q  <= 1'b0;
            mem_re       <= 1'b0;
            mem_addr     <= '0;
            ser_en       <= 1'b0;
            word_valid   <= 1'b0;
            word_row_end <= 1'b0;
            word_last    <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            ser_en       <= (state == ISSUE);
            rd_q         <= mem_re;
            fin_q        <= (state == ISSUE) && last_slot;
            word_valid   <= fin_q;
            word_row_end <= fin_q && row_end_q;
            word_last    <= fin_q && tile_last_q;
            case (state)
                IDLE: begin
                    mem_re <= 1'b0;
                    if (start) begin
                        row_base <= base_addr;
                        w_r      <= img_w;
                        h_r      <= img_h;
                        pitch_r  <= pitch;
                        row      <= '0;
                        col      <= '0;
                        state    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    mem_re <= 1'b0;
                    if (!remain) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (pe_ready) begin
                        lane     <= '0;
                        mem_re   <= slot_rd;
                        mem_addr <= row_base + ADDR_W'(col);
                        if (slot_rd) col <= col + 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_slot) begin
                        mem_re      <= 1'b0;
                        row_end_q   <= col_done;
                        tile_last_q <= col_done && (({1'b0, row} + 1'b1) >= {1'b0, h_r});
                        if (col_done) begin
                            col      <= '0;
                            row      <= row + 1'b1;
                            row_base <= row_base + ADDR_W'(pitch_r);
                        end
                        state <= WAIT_RDY;
                    end else begin
                        lane     <= lane + 1'b1;
                        mem_re   <= slot_rd;
                        mem_addr <= row_base + ADDR_W'(col);
                        if (slot_rd) col <= col + 1'b1;
                    end
                end
                default: begin
                    mem_re <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifmap_fetch.sv
// tb/tb_ifmap_fetch.sv - self-checking bench for ifmap_fetch with directed vectors, timing sequences and a random tile model
module tb_ifmap_fetch;
    logic        clk = 1'b0;
    logic        rst_n, start, pe_ready;
    logic [15:0] base_addr;
    logic [9:0]  img_w, img_h, pitch;
    logic        mem_re, ser_en, word_valid, word_row_end, word_last, busy, done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  ser_data;

    ifmap_fetch #(.BUS(31), .ADDR_W(16), .DIM_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .img_w(img_w), .img_h(img_h), .pitch(pitch),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ser_en(ser_en), .ser_data(ser_data), .pe_ready(pe_ready),
        .word_valid(word_valid), .word_row_end(word_row_end), .word_last(word_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM: byte at address a is a[7:0], one-cycle read latency
    always @(posedge clk) if (mem_re) mem_rdata <= mem_addr[7:0];

    // packer model plus observation queues: {row_end, last, word}
    logic [31:0] pack = '0;
    logic [33:0] obs_words[$];
    logic [15:0] obs_addr[$];
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (word_valid) obs_words.push_back({word_row_end, word_last, pack});
        if (ser_en) pack = {ser_data, pack[31:8]};
        if (mem_re) obs_addr.push_back(mem_addr);
        if (done) done_cnt++;
    end

    logic [33:0] exp_words[$];
    logic [15:0] exp_addr[$];

    task automatic build_model(input logic [15:0] b, input logic [9:0] w, h, p);
        int nw;
        logic [31:0] d;
        logic [15:0] a;
        exp_words.delete();
        exp_addr.delete();
        if (w == 0) return;
        nw = (int'(w) + 3) / 4;
        for (int r = 0; r < int'(h); r++) begin
            for (int j = 0; j < nw; j++) begin
                d = '0;
                for (int i = 0; i < 4; i++) begin
                    int c = j * 4 + i;
                    if (c < int'(w)) begin
                        a = 16'(int'(b) + r * int'(p) + c);
                        exp_addr.push_back(a);
                        d[8*i +: 8] = a[7:0];
                    end
                end
                exp_words.push_back({j == nw - 1, (j == nw - 1) && (r == int'(h) - 1), d});
            end
        end
    endtask

    task automatic run_tile(input logic [15:0] b, input logic [9:0] w, h, p, input bit rnd);
        bit ok = 0;
        int bad = 0;
        obs_words.delete();
        obs_addr.delete();
        done_cnt = 0;
        @(negedge clk);
        base_addr = b; img_w = w; img_h = h; pitch = p; start = 1'b1; pe_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin ok = 1; break; end
            pe_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check("done_seen", 64'(ok), 64'd1);
        build_model(b, w, h, p);
        check("n_words", 64'(obs_words.size()), 64'(exp_words.size()));
        for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++)
            check("word", 64'(obs_words[i]), 64'(exp_words[i]));
        if (obs_addr.size() != exp_addr.size()) bad++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i]) bad++;
        check("addr_seq_errs", 64'(bad), 64'd0);
        check("done_cnt", 64'(done_cnt), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic seq(input logic [15:0] b, input logic [9:0] w, h, p, input int lo_from, lo_to,
                       output logic [31:0] re_m, se_m, wv_m, dn_m, bz_m);
        re_m = '0; se_m = '0; wv_m = '0; dn_m = '0; bz_m = '0;
        obs_words.delete();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            re_m[c] = mem_re; se_m[c] = ser_en; wv_m[c] = word_valid; dn_m[c] = done; bz_m[c] = busy;
            if (c == 0) begin base_addr = b; img_w = w; img_h = h; pitch = p; end
            start = (c == 0);
            pe_ready = !(c >= lo_from && c < lo_to);
        end
    endtask

    typedef struct {
        logic [15:0] base;
        logic [9:0]  w, h, p;
        int          n_words;
        logic [31:0] first, last;
        int          n_reads;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] re_m, se_m, wv_m, dn_m, bz_m;
    logic        act;

    initial begin
        vecs[0] = '{16'h0100, 10'd8, 10'd1, 10'd0,    2, 32'h03020100, 32'h07060504, 8};
        vecs[1] = '{16'h0100, 10'd6, 10'd1, 10'd0,    2, 32'h03020100, 32'h00000504, 6};
        vecs[2] = '{16'h0100, 10'd4, 10'd2, 10'h020,  2, 32'h03020100, 32'h23222120, 8};
        vecs[3] = '{16'h0100, 10'd0, 10'd3, 10'h010,  0, 32'h0,        32'h0,        0};
        vecs[4] = '{16'h0100, 10'd5, 10'd0, 10'h010,  0, 32'h0,        32'h0,        0};
        vecs[5] = '{16'hFFFE, 10'd4, 10'd1, 10'd0,    1, 32'h0100FFFE, 32'h0100FFFE, 4};
        vecs[6] = '{16'h0200, 10'd9, 10'd2, 10'h010,  6, 32'h03020100, 32'h00000018, 18};

        rst_n = 1'b0; start = 1'b0; pe_ready = 1'b0;
        base_addr = '0; img_w = '0; img_h = '0; pitch = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {mem_re, mem_addr, ser_en, ser_data, word_valid, word_row_end, word_last, busy, done}, 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_tile(vecs[v].base, vecs[v].w, vecs[v].h, vecs[v].p, 1'b0);
            check("vec_n_words", 64'(obs_words.size()), 64'(vecs[v].n_words));
            check("vec_n_reads", 64'(obs_addr.size()), 64'(vecs[v].n_reads));
            if (vecs[v].n_words > 0 && obs_words.size() > 0) begin
                check("vec_first", 64'(obs_words[0][31:0]), 64'(vecs[v].first));
                check("vec_last", 64'(obs_words[obs_words.size()-1][31:0]), 64'(vecs[v].last));
            end
        end

        // back-to-back word timing: WAIT_RDY at 1, slots 2-5 and 7-10
        seq(16'h0100, 10'd8, 10'd1, 10'd0, 100, 100, re_m, se_m, wv_m, dn_m, bz_m);
        check("t_mem_re", re_m, 32'h000007BC);
        check("t_ser_en", se_m, 32'h00000F78);
        check("t_word_valid", wv_m, 32'h00001080);
        check("t_done", dn_m, 32'h00001000);
        check("t_busy", bz_m, 32'h00001FFE);

        // pe_ready low for cycles 2..11, second word starts at 13
        seq(16'h0100, 10'd8, 10'd1, 10'd0, 2, 12, re_m, se_m, wv_m, dn_m, bz_m);
        check("s_mem_re", re_m, 32'h0001E03C);
        check("s_ser_en", se_m, 32'h0003C078);
        check("s_word_valid", wv_m, 32'h00040080);
        check("s_done", dn_m, 32'h00040000);
        check("s_busy", bz_m, 32'h0007FFFE);
        check("s_n_words", 64'(obs_words.size()), 64'd2);
        if (obs_words.size() == 2) begin
            check("s_word0", 64'(obs_words[0]), 64'({2'b00, 32'h03020100}));
            check("s_word1", 64'(obs_words[1]), 64'({2'b11, 32'h07060504}));
        end

        seq(16'h0100, 10'd0, 10'd3, 10'd0, 100, 100, re_m, se_m, wv_m, dn_m, bz_m);
        check("z_activity", {re_m, se_m | wv_m}, 64'd0);
        check("z_done", dn_m, 32'h00000004);
        check("z_busy", bz_m, 32'h00000006);
        seq(16'h0100, 10'd5, 10'd0, 10'd0, 100, 100, re_m, se_m, wv_m, dn_m, bz_m);
        check("z2_activity", {re_m, se_m | wv_m}, 64'd0);
        check("z2_done", dn_m, 32'h00000004);

        // reset asserted in the middle of a word of a two-row tile
        @(negedge clk);
        base_addr = 16'h0100; img_w = 10'd8; img_h = 10'd2; pitch = 10'h020; start = 1'b1; pe_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !mem_re; i++) @(negedge clk);
        check("mid_reached", 64'(mem_re), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {mem_re, mem_addr, ser_en, ser_data, word_valid, word_row_end, word_last, busy, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_outputs", {mem_re, mem_addr, ser_en, ser_data, word_valid, word_row_end, word_last, busy, done}, 64'd0);
        rst_n = 1'b1;
        obs_words.delete();
        done_cnt = 0;
        act = 1'b0;
        repeat (12) begin
            @(negedge clk);
            act = act | mem_re | ser_en | word_valid | done | busy;
        end
        check("post_rst_quiet", 64'(act), 64'd0);
        check("post_rst_stale", 64'(obs_words.size() + done_cnt), 64'd0);
        run_tile(16'h0100, 10'd8, 10'd1, 10'd0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            run_tile(16'($urandom), 10'($urandom_range(0, 11)), 10'($urandom_range(0, 4)),
                     10'($urandom_range(0, 63)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
